// File: rtl/ex_result_buffer.sv
// ---------------------------------------------------------------------------
// ex_result_buffer
//   Two-entry elastic buffer between the ALU (execute) and the
//   memory/writeback stage. Each accepted instruction's ALU result,
//   destination and resolved branch decision are stored. The head entry is
//   presented downstream and is also forwarded back to operand selection.
//
//   Optional build macro: EX_RESULT_BUFFER_STATS_EN
//     When defined, a 16-bit saturating stall counter output is added.
//
// Ports
//   clk, rst           : clock (rising edge), async active-high reset
//   in_valid/in_ready  : upstream handshake
//   alu_result         : ALU output to store
//   comp_result        : comparison result, only bit 0 is used
//   rd_addr, wb_en     : destination register and write enable
//   is_branch          : instruction is a conditional branch
//   branch_target      : branch target address
//   flush              : discard all buffered and incoming entries
//   out_valid/out_ready: downstream handshake
//   out_result, out_rd_addr, out_wb_en, out_branch_taken, out_branch_target
//                      : head entry fields (zero when out_valid=0)
//   fwd_valid, fwd_rd_addr, fwd_result
//                      : head forwarding information
//   stall_count        : (stats build only) upstream stall cycles
// ---------------------------------------------------------------------------
module ex_result_buffer #(
  parameter int OPERAND_LENGTH = 32,
  parameter int REG_ADDR_WIDTH = 5
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic                      in_valid,
  output logic                      in_ready,
  input  logic [OPERAND_LENGTH-1:0] alu_result,
  input  logic [OPERAND_LENGTH-1:0] comp_result,
  input  logic [REG_ADDR_WIDTH-1:0] rd_addr,
  input  logic                      wb_en,
  input  logic                      is_branch,
  input  logic [OPERAND_LENGTH-1:0] branch_target,
  input  logic                      flush,
  output logic                      out_valid,
  input  logic                      out_ready,
  output logic [OPERAND_LENGTH-1:0] out_result,
  output logic [REG_ADDR_WIDTH-1:0] out_rd_addr,
  output logic                      out_wb_en,
  output logic                      out_branch_taken,
  output logic [OPERAND_LENGTH-1:0] out_branch_target,
  output logic                      fwd_valid,
  output logic [REG_ADDR_WIDTH-1:0] fwd_rd_addr,
  output logic [OPERAND_LENGTH-1:0] fwd_result
`ifdef EX_RESULT_BUFFER_STATS_EN
  ,
  output logic [15:0]               stall_count
`endif
);

  typedef enum logic [1:0] {
    EMPTY = 2'd0,
    ONE   = 2'd1,
    FULL  = 2'd2
  } state_e;

  state_e state_q, state_d;
  logic   head_q, head_d;
  logic   tail_q, tail_d;

  logic [OPERAND_LENGTH-1:0] result_q [2];
  logic [REG_ADDR_WIDTH-1:0] rd_q     [2];
  logic                      wen_q    [2];
  logic                      taken_q  [2];
  logic [OPERAND_LENGTH-1:0] target_q [2];

  logic push_s;
  logic pop_s;
  logic wen_s;
  logic taken_s;

  // Only bit 0 of the comparison result carries the branch decision.
  logic unused_comp_s;
  assign unused_comp_s = ^comp_result[OPERAND_LENGTH-1:1];

  // Readiness and validity depend only on registered state.
  assign in_ready  = (state_q != FULL);
  assign out_valid = (state_q == ONE) || (state_q == FULL);

  // Flush blocks both sides of the buffer in the same cycle.
  assign push_s = in_valid & in_ready & ~flush;
  assign pop_s  = out_valid & out_ready & ~flush;

  // x0 writes and branches never update the register file.
  assign wen_s   = wb_en & ~is_branch & (rd_addr != {REG_ADDR_WIDTH{1'b0}});
  assign taken_s = is_branch & comp_result[0];

  // State and pointer registers.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= EMPTY;
      head_q  <= 1'b0;
      tail_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      head_q  <= head_d;
      tail_q  <= tail_d;
    end
  end

  // Next-state and pointer update logic.
  always_comb begin
    state_d = state_q;
    head_d  = head_q;
    tail_d  = tail_q;
    if (flush) begin
      state_d = EMPTY;
      head_d  = 1'b0;
      tail_d  = 1'b0;
    end else begin
      if (push_s) begin
        tail_d = ~tail_q;
      end else begin
        tail_d = tail_q;
      end
      if (pop_s) begin
        head_d = ~head_q;
      end else begin
        head_d = head_q;
      end
      case (state_q)
        EMPTY: begin
          if (push_s) begin
            state_d = ONE;
          end else begin
            state_d = EMPTY;
          end
        end
        ONE: begin
          if (push_s && !pop_s) begin
            state_d = FULL;
          end else if (pop_s && !push_s) begin
            state_d = EMPTY;
          end else begin
            state_d = ONE;
          end
        end
        FULL: begin
          if (pop_s) begin
            state_d = ONE;
          end else begin
            state_d = FULL;
          end
        end
        default: begin
          state_d = EMPTY;
          head_d  = 1'b0;
          tail_d  = 1'b0;
        end
      endcase
    end
  end

  // Entry storage, written at the tail pointer on each accepted push.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < 2; i++) begin
        result_q[i] <= {OPERAND_LENGTH{1'b0}};
        rd_q[i]     <= {REG_ADDR_WIDTH{1'b0}};
        wen_q[i]    <= 1'b0;
        taken_q[i]  <= 1'b0;
        target_q[i] <= {OPERAND_LENGTH{1'b0}};
      end
    end else if (push_s) begin
      result_q[tail_q] <= alu_result;
      rd_q[tail_q]     <= rd_addr;
      wen_q[tail_q]    <= wen_s;
      taken_q[tail_q]  <= taken_s;
      target_q[tail_q] <= branch_target;
    end
  end

  // Head presentation; every field reads zero while the buffer is empty.
  always_comb begin
    out_result        = {OPERAND_LENGTH{1'b0}};
    out_rd_addr       = {REG_ADDR_WIDTH{1'b0}};
    out_wb_en         = 1'b0;
    out_branch_taken  = 1'b0;
    out_branch_target = {OPERAND_LENGTH{1'b0}};
    if (out_valid) begin
      out_result        = result_q[head_q];
      out_rd_addr       = rd_q[head_q];
      out_wb_en         = wen_q[head_q];
      out_branch_taken  = taken_q[head_q];
      out_branch_target = target_q[head_q];
    end else begin
      out_result        = {OPERAND_LENGTH{1'b0}};
      out_rd_addr       = {REG_ADDR_WIDTH{1'b0}};
      out_wb_en         = 1'b0;
      out_branch_taken  = 1'b0;
      out_branch_target = {OPERAND_LENGTH{1'b0}};
    end
  end

  assign fwd_valid   = out_wb_en;
  assign fwd_rd_addr = out_rd_addr;
  assign fwd_result  = out_result;

`ifdef EX_RESULT_BUFFER_STATS_EN
  logic [15:0] stall_cnt_q, stall_cnt_d;

  // Saturating count of cycles where upstream offers but cannot be accepted.
  always_comb begin
    stall_cnt_d = stall_cnt_q;
    if (in_valid && !in_ready && (stall_cnt_q != 16'hFFFF)) begin
      stall_cnt_d = stall_cnt_q + 16'd1;
    end else begin
      stall_cnt_d = stall_cnt_q;
    end
  end

  // Stall counter register; only reset clears it, flush does not.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      stall_cnt_q <= 16'd0;
    end else begin
      stall_cnt_q <= stall_cnt_d;
    end
  end

  assign stall_count = stall_cnt_q;
`endif

endmodule

// File: tb/tb_ex_result_buffer.sv
// ---------------------------------------------------------------------------
// tb_ex_result_buffer
//   Directed self-checking bench for ex_result_buffer with hand-computed
//   expected values. Define EX_RESULT_BUFFER_STATS_EN to also cover the
//   stall counter.
// ---------------------------------------------------------------------------
module tb_ex_result_buffer;

  logic        clk = 1'b0;
  logic        rst;
  logic        in_valid;
  logic        in_ready;
  logic [31:0] alu_result;
  logic [31:0] comp_result;
  logic [4:0]  rd_addr;
  logic        wb_en;
  logic        is_branch;
  logic [31:0] branch_target;
  logic        flush;
  logic        out_valid;
  logic        out_ready;
  logic [31:0] out_result;
  logic [4:0]  out_rd_addr;
  logic        out_wb_en;
  logic        out_branch_taken;
  logic [31:0] out_branch_target;
  logic        fwd_valid;
  logic [4:0]  fwd_rd_addr;
  logic [31:0] fwd_result;
`ifdef EX_RESULT_BUFFER_STATS_EN
  logic [15:0] stall_count;
`endif

  int errors = 0;
  int checks = 0;

  ex_result_buffer #(
    .OPERAND_LENGTH(32),
    .REG_ADDR_WIDTH(5)
  ) dut (
    .clk              (clk),
    .rst              (rst),
    .in_valid         (in_valid),
    .in_ready         (in_ready),
    .alu_result       (alu_result),
    .comp_result      (comp_result),
    .rd_addr          (rd_addr),
    .wb_en            (wb_en),
    .is_branch        (is_branch),
    .branch_target    (branch_target),
    .flush            (flush),
    .out_valid        (out_valid),
    .out_ready        (out_ready),
    .out_result       (out_result),
    .out_rd_addr      (out_rd_addr),
    .out_wb_en        (out_wb_en),
    .out_branch_taken (out_branch_taken),
    .out_branch_target(out_branch_target),
    .fwd_valid        (fwd_valid),
    .fwd_rd_addr      (fwd_rd_addr),
    .fwd_result       (fwd_result)
`ifdef EX_RESULT_BUFFER_STATS_EN
    ,
    .stall_count      (stall_count)
`endif
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Advance one clock and settle 1 time unit past the rising edge.
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  initial begin
    rst = 1'b1; in_valid = 1'b0; alu_result = 32'd0; comp_result = 32'd0;
    rd_addr = 5'd0; wb_en = 1'b0; is_branch = 1'b0; branch_target = 32'd0;
    flush = 1'b0; out_ready = 1'b0;
    step(); step();
    chk("rst_out_valid", {31'd0, out_valid}, 32'd0);
    chk("rst_in_ready", {31'd0, in_ready}, 32'd1);
    chk("rst_out_result", out_result, 32'd0);
    chk("rst_fwd_valid", {31'd0, fwd_valid}, 32'd0);
    chk("rst_taken", {31'd0, out_branch_taken}, 32'd0);
`ifdef EX_RESULT_BUFFER_STATS_EN
    chk("rst_stall", {16'd0, stall_count}, 32'd0);
`endif
    rst = 1'b0;

    // Single push, one-cycle latency to out_valid.
    in_valid = 1'b1; alu_result = 32'd8; rd_addr = 5'd3; wb_en = 1'b1; out_ready = 1'b1;
    step();
    in_valid = 1'b0;
    chk("p1_out_valid", {31'd0, out_valid}, 32'd1);
    chk("p1_out_result", out_result, 32'd8);
    chk("p1_out_wb_en", {31'd0, out_wb_en}, 32'd1);
    chk("p1_fwd_valid", {31'd0, fwd_valid}, 32'd1);
    chk("p1_fwd_rd", {27'd0, fwd_rd_addr}, 32'd3);
    chk("p1_fwd_result", fwd_result, 32'd8);
    step();
    chk("p1_drained", {31'd0, out_valid}, 32'd0);
    chk("p1_zero_data", out_result, 32'd0);

    // Fill with downstream stalled; third offer is refused.
    out_ready = 1'b0; in_valid = 1'b1; alu_result = 32'h11; rd_addr = 5'd1;
    step();
    chk("f_in_ready_one", {31'd0, in_ready}, 32'd1);
    alu_result = 32'h22; rd_addr = 5'd2;
    step();
    chk("f_in_ready_full", {31'd0, in_ready}, 32'd0);
    alu_result = 32'h33; rd_addr = 5'd7;
    step();
    chk("f_still_full", {31'd0, in_ready}, 32'd0);
    chk("f_head_stable", out_result, 32'h11);
    chk("f_head_rd", {27'd0, out_rd_addr}, 32'd1);
    in_valid = 1'b0; out_ready = 1'b1;
    step();
    chk("f_second", out_result, 32'h22);
    chk("f_ready_back", {31'd0, in_ready}, 32'd1);
    step();
    chk("f_no_33", {31'd0, out_valid}, 32'd0);
`ifdef EX_RESULT_BUFFER_STATS_EN
    chk("f_stall", {16'd0, stall_count}, 32'd1);
`endif

    // Taken branch, then not-taken branch (only comp_result bit 0 counts).
    out_ready = 1'b0; in_valid = 1'b1; is_branch = 1'b1; comp_result = 32'd1;
    branch_target = 32'h40; wb_en = 1'b1; rd_addr = 5'd5; alu_result = 32'h99;
    step();
    chk("b1_taken", {31'd0, out_branch_taken}, 32'd1);
    chk("b1_target", out_branch_target, 32'h40);
    chk("b1_wb_en", {31'd0, out_wb_en}, 32'd0);
    chk("b1_fwd_valid", {31'd0, fwd_valid}, 32'd0);
    comp_result = 32'h2; branch_target = 32'h80;
    step();
    in_valid = 1'b0; out_ready = 1'b1;
    step();
    chk("b2_valid", {31'd0, out_valid}, 32'd1);
    chk("b2_taken", {31'd0, out_branch_taken}, 32'd0);
    chk("b2_target", out_branch_target, 32'h80);
    step();
    is_branch = 1'b0; comp_result = 32'd0; branch_target = 32'd0;

    // Write to x0 never writes back.
    in_valid = 1'b1; wb_en = 1'b1; rd_addr = 5'd0; alu_result = 32'hFF;
    step();
    chk("x0_valid", {31'd0, out_valid}, 32'd1);
    chk("x0_result", out_result, 32'hFF);
    chk("x0_wb_en", {31'd0, out_wb_en}, 32'd0);
    chk("x0_fwd_valid", {31'd0, fwd_valid}, 32'd0);

    // Simultaneous push and pop in ONE keeps one entry, head advances.
    alu_result = 32'hB0; rd_addr = 5'd9;
    step();
    chk("pp_valid", {31'd0, out_valid}, 32'd1);
    chk("pp_result", out_result, 32'hB0);
    chk("pp_ready", {31'd0, in_ready}, 32'd1);
    in_valid = 1'b0;
    step();
    chk("pp_drained", {31'd0, out_valid}, 32'd0);

    // Fill, hold full for 5 offered cycles, then flush with an incoming offer.
    out_ready = 1'b0; in_valid = 1'b1; alu_result = 32'hA1; rd_addr = 5'd4;
    step();
    alu_result = 32'hA2;
    step();
    alu_result = 32'hA3;
    for (int i = 0; i < 5; i++) step();
    chk("h_full", {31'd0, in_ready}, 32'd0);
`ifdef EX_RESULT_BUFFER_STATS_EN
    chk("h_stall", {16'd0, stall_count}, 32'd6);
`endif
    flush = 1'b1; out_ready = 1'b1; alu_result = 32'hEE;
    step();
    flush = 1'b0; out_ready = 1'b0;
    chk("fl_valid", {31'd0, out_valid}, 32'd0);
    chk("fl_ready", {31'd0, in_ready}, 32'd1);
    chk("fl_result", out_result, 32'd0);
    in_valid = 1'b0;
    step();
    chk("fl_no_ee", {31'd0, out_valid}, 32'd0);
`ifdef EX_RESULT_BUFFER_STATS_EN
    chk("fl_stall_kept", {16'd0, stall_count}, 32'd7);
`endif
    in_valid = 1'b1; alu_result = 32'h55; rd_addr = 5'd6;
    step();
    in_valid = 1'b0;
    chk("post_fl_result", out_result, 32'h55);

    // Asynchronous reset between clock edges.
    #2 rst = 1'b1;
    #1;
    chk("ar_valid", {31'd0, out_valid}, 32'd0);
    chk("ar_ready", {31'd0, in_ready}, 32'd1);
`ifdef EX_RESULT_BUFFER_STATS_EN
    chk("ar_stall", {16'd0, stall_count}, 32'd0);
`endif
    step();
    rst = 1'b0;
    step();
    chk("ar_after", {31'd0, out_valid}, 32'd0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/ex_result_buffer.md
Name: ex_result_buffer

Overview:
- Two-entry elastic buffer directly downstream of the ALU, between the execute stage and the memory/writeback stage.
- Captures alu_result, comp_result and destination info each time the execute stage offers an instruction.
- Resolves the branch decision from comp_result[0] and drives head-of-buffer forwarding data back to operand selection.
- Provides valid/ready backpressure so a stalled writeback stage does not lose ALU results.

Parameters:
- OPERAND_LENGTH, 32, width of ALU operands and results (OPERAND_LENGTH >= 2).
- REG_ADDR_WIDTH, 5, register-file address width.

Ports:
- clk  in  1  clock, rising edge.
- rst  in  1  asynchronous, active-high reset.
- in_valid  in  1  execute stage presents an instruction.
- in_ready  out  1  buffer can accept this cycle.
- alu_result  in  OPERAND_LENGTH  ALU output.
- comp_result  in  OPERAND_LENGTH  comparison unit output; only bit 0 is meaningful.
- rd_addr  in  REG_ADDR_WIDTH  destination register.
- wb_en  in  1  instruction writes rd.
- is_branch  in  1  instruction is a conditional branch.
- branch_target  in  OPERAND_LENGTH  branch target address.
- flush  in  1  discard all buffered and incoming entries.
- out_valid  out  1  head entry valid.
- out_ready  in  1  downstream accepts head.
- out_result  out  OPERAND_LENGTH  head alu_result.
- out_rd_addr  out  REG_ADDR_WIDTH  head rd.
- out_wb_en  out  1  head effective write enable.
- out_branch_taken  out  1  head is a taken branch.
- out_branch_target  out  OPERAND_LENGTH  head branch target.
- fwd_valid  out  1  head valid and writes a register.
- fwd_rd_addr  out  REG_ADDR_WIDTH  forwarding destination.
- fwd_result  out  OPERAND_LENGTH  forwarding value.

Behaviour:
- Reset is asynchronous and active-high on rst; single clock clk.
- On reset: count=0, entries cleared, out_valid=0, in_ready=1, all data outputs 0, fwd_valid=0, out_branch_taken=0.
- State is the entry count: EMPTY(0), ONE(1), FULL(2). Storage is a 2-entry circular array with 1-bit head/tail pointers that wrap 1->0.
- in_ready = (count != 2). It depends only on registered state, never on out_ready.
- push = in_valid & in_ready & ~flush. pop = out_valid & out_ready.
- Transitions:
  - EMPTY --push--> ONE.
  - ONE --push & ~pop--> FULL.
  - ONE --pop & ~push--> EMPTY.
  - ONE --push & pop--> ONE (head advances, tail advances).
  - FULL --pop--> ONE.
- No combinational bypass. Latency from accept to out_valid is exactly 1 cycle.
- Stored fields per entry:
  - result = alu_result.
  - rd = rd_addr.
  - wen = wb_en & ~is_branch & (rd_addr != 0). A write to x0 or a branch never writes.
  - taken = is_branch & comp_result[0].
  - target = branch_target.
- Data outputs show the head entry when out_valid=1 and are forced to 0 when out_valid=0.
- out_branch_taken = out_valid & head.taken.
- fwd_valid = out_valid & head.wen. fwd_rd_addr and fwd_result mirror the head.
- Head data is stable while out_valid=1 & out_ready=0.
- Flush (synchronous, registered): next cycle count=0 and pointers=0. Flush overrides push and pop in the same cycle; the incoming instruction is dropped and no handshake completes downstream. The entry contents may remain, but all outputs read 0 because out_valid=0.
- Reset asserted mid-operation clears the buffer immediately, independent of clk.

Optional Feature:
- Macro: EX_RESULT_BUFFER_STATS_EN.
- Defined:
  - Adds output stall_count (16 bits).
  - Increments every cycle with in_valid=1 & in_ready=0, saturating at 16'hFFFF.
  - Cleared only by rst, not by flush.
- Undefined: the port and counter do not exist; all other behaviour is identical.

Test Plan:
- Reset -> out_valid=0, in_ready=1, out_result=0. Then push alu_result=8, rd=3, wb_en=1 with out_ready=1 -> next cycle out_valid=1, out_result=8, out_wb_en=1, fwd_valid=1, fwd_rd_addr=3.
- out_ready=0; push 0x11, 0x22, then 0x33 -> in_ready=0 after the second push, 0x33 not accepted. Raise out_ready -> outputs 0x11 then 0x22 in order, in_ready returns to 1 after the first pop.
- Push is_branch=1 with comp_result=1, target=0x40, then is_branch=1 with comp_result=0 -> out_branch_taken=1, target 0x40, out_wb_en=0 for the first; out_branch_taken=0 for the second.
- Push wb_en=1, rd=0, alu_result=0xFF -> out_valid=1, out_wb_en=0, fwd_valid=0.
- Buffer FULL, assert flush together with in_valid=1 -> next cycle out_valid=0, in_ready=1, count 0, flushed input never appears. Assert rst between clock edges -> out_valid drops immediately.
- With EX_RESULT_BUFFER_STATS_EN defined: hold FULL with in_valid=1 for 5 cycles -> stall_count=5; a flush does not clear it.
